// File: rtl/bp_pkg.sv
// Shared branch-predictor types: the predictor update record, default update
// queue depth and a saturating-increment helper for perf counters.
package bp_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
  } ibp_upd_t;

  localparam int IBP_UPD_DEPTH = 4;

  // Increments v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Generic single-clock FIFO; push is ignored when full and pop when empty.
// Storage is not reset, only the pointers and occupancy count.
module bp_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         data_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ibp_update_queue.sv
// Buffers resolved indirect branches and drains them to the predictor update
// port; tracks lookup history and perf counters. Option: IBP_UPD_FILTER_EN.
module ibp_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = IBP_UPD_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [63:0]      res_pc_i,
  input  logic [63:0]      res_target_i,
  input  logic [63:0]      res_pred_target_i,
  input  logic             upd_stall_i,
  output logic             update_valid_o,
  output logic [63:0]      update_pc_o,
  output logic [63:0]      update_target_o,
  output logic [63:0]      last_target_o,
  output logic [CNT_W-1:0] mispredict_cnt_o,
  output logic [CNT_W-1:0] resolve_cnt_o
);

  ibp_upd_t               enq_entry, head_entry;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   accept, mispredict, enqueue;

  logic [63:0]      last_target_q, last_target_d;
  logic [CNT_W-1:0] mis_cnt_q,     mis_cnt_d;
  logic [CNT_W-1:0] res_cnt_q,     res_cnt_d;

  assign res_ready_o = !fifo_full;
  assign accept      = res_valid_i && res_ready_o;
  assign mispredict  = (res_pred_target_i != res_target_i);

`ifdef IBP_UPD_FILTER_EN
  // Correct predictions need no training, so only mispredicts reach the predictor.
  assign enqueue = accept && mispredict;
`else
  assign enqueue = accept;
`endif

  assign enq_entry.pc     = res_pc_i;
  assign enq_entry.target = res_target_i;

  assign update_valid_o  = !fifo_empty && !upd_stall_i;
  assign update_pc_o     = fifo_empty ? 64'd0 : head_entry.pc;
  assign update_target_o = fifo_empty ? 64'd0 : head_entry.target;

  bp_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (ibp_upd_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (enqueue),
    .pop_i   (update_valid_o),
    .data_i  (enq_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    last_target_d = last_target_q;
    mis_cnt_d     = mis_cnt_q;
    res_cnt_d     = res_cnt_q;
    if (accept) begin
      last_target_d = res_target_i;
      res_cnt_d     = CNT_W'(sat_inc(64'(res_cnt_q), CNT_W));
      if (mispredict) mis_cnt_d = CNT_W'(sat_inc(64'(mis_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_target_q <= '0;
      mis_cnt_q     <= '0;
      res_cnt_q     <= '0;
    end else begin
      last_target_q <= last_target_d;
      mis_cnt_q     <= mis_cnt_d;
      res_cnt_q     <= res_cnt_d;
    end
  end

  assign last_target_o    = last_target_q;
  assign mispredict_cnt_o = mis_cnt_q;
  assign resolve_cnt_o    = res_cnt_q;

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_ibp_update_queue.sv
// Scoreboard bench for ibp_update_queue: stimulus pushes expected updates,
// a negedge monitor pops and compares every update the DUT emits.
module tb_ibp_update_queue;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [63:0]      res_pc_i, res_target_i, res_pred_target_i;
  logic             upd_stall_i;
  logic             update_valid_o;
  logic [63:0]      update_pc_o, update_target_o, last_target_o;
  logic [CNT_W-1:0] mispredict_cnt_o, resolve_cnt_o;

  always #5 clk = ~clk;

  ibp_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .res_valid_i       (res_valid_i),
    .res_ready_o       (res_ready_o),
    .res_pc_i          (res_pc_i),
    .res_target_i      (res_target_i),
    .res_pred_target_i (res_pred_target_i),
    .upd_stall_i       (upd_stall_i),
    .update_valid_o    (update_valid_o),
    .update_pc_o       (update_pc_o),
    .update_target_o   (update_target_o),
    .last_target_o     (last_target_o),
    .mispredict_cnt_o  (mispredict_cnt_o),
    .resolve_cnt_o     (resolve_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  ibp_upd_t         exp_q[$];
  logic [63:0]      m_last;
  logic [CNT_W-1:0] m_res, m_mis;
  logic             acc_flag, vld_flag;

  function automatic logic [CNT_W-1:0] sinc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && update_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: got pc=0x%0h target=0x%0h expected no update",
                 update_pc_o, update_target_o);
      end else begin
        ibp_upd_t e;
        e = exp_q.pop_front();
        check64("upd_pc", update_pc_o, e.pc);
        check64("upd_target", update_target_o, e.target);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_last = '0;
    m_res  = '0;
    m_mis  = '0;
  endtask

  // Call just after a posedge; returns just after the edge that samples the offer.
  task automatic offer(input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] pred);
    ibp_upd_t e;
    res_valid_i       = 1'b1;
    res_pc_i          = pc;
    res_target_i      = tgt;
    res_pred_target_i = pred;
    @(negedge clk);
    acc_flag = res_ready_o;
    vld_flag = update_valid_o;
    if (acc_flag) begin
      m_last = tgt;
      m_res  = sinc(m_res);
      if (pred != tgt) m_mis = sinc(m_mis);
      e.pc     = pc;
      e.target = tgt;
`ifdef IBP_UPD_FILTER_EN
      if (pred != tgt) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
    sync();
    res_valid_i = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check64({tag, "_last"}, last_target_o, m_last);
    check64({tag, "_res"}, 64'(resolve_cnt_o), 64'(m_res));
    check64({tag, "_mis"}, 64'(mispredict_cnt_o), 64'(m_mis));
  endtask

  initial begin
    rst_n = 1'b0;
    res_valid_i = 1'b0;
    res_pc_i = '0;
    res_target_i = '0;
    res_pred_target_i = '0;
    upd_stall_i = 1'b0;
    model_clear();
    repeat (2) sync();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check64("rst_valid", 64'(update_valid_o), 64'd0);
    check64("rst_ready", 64'(res_ready_o), 64'd1);
    check64("rst_pc", update_pc_o, 64'd0);
    check64("rst_target", update_target_o, 64'd0);
    check_counters("rst");
    sync();

    // Single resolve: update one cycle after acceptance, no bypass
    offer(64'h1000, 64'h2000, 64'h0);
    check64("t1_no_bypass", 64'(vld_flag), 64'd0);
    @(negedge clk);
    check64("t1_valid", 64'(update_valid_o), 64'd1);
    check64("t1_pc", update_pc_o, 64'h1000);
    check64("t1_last", last_target_o, 64'h2000);
    check64("t1_mis", 64'(mispredict_cnt_o), 64'd1);
    check64("t1_res", 64'(resolve_cnt_o), 64'd1);
    sync();
    @(negedge clk);
    check64("t1_drained", 64'(update_valid_o), 64'd0);
    sync();

    // Stalled fill to full, then drain
    upd_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(64'h10 * (i + 1), 64'h5000 + 64'(i), 64'h0);
      check64($sformatf("t2_acc%0d", i), 64'(acc_flag), (i < 4) ? 64'd1 : 64'd0);
    end
    check64("t2_full_ready", 64'(res_ready_o), 64'd0);
    upd_stall_i = 1'b0;
    @(negedge clk);
    check64("t2_pop0_valid", 64'(update_valid_o), 64'd1);
    check64("t2_pop0_ready", 64'(res_ready_o), 64'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check64($sformatf("t2_pop%0d_valid", i), 64'(update_valid_o), 64'd1);
      check64($sformatf("t2_pop%0d_ready", i), 64'(res_ready_o), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    check64("t2_empty", 64'(update_valid_o), 64'd0);
    check_counters("t2");
    sync();

    // Full-rate push+pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      offer(64'h200 + 64'(i * 8), 64'h3000 + 64'(i), 64'h1);
      check64($sformatf("t3_acc%0d", i), 64'(acc_flag), 64'd1);
      if (i > 0) check64($sformatf("t3_vld%0d", i), 64'(vld_flag), 64'd1);
    end
    @(negedge clk);
    check64("t3_last_valid", 64'(update_valid_o), 64'd1);
    sync();
    @(negedge clk);
    check64("t3_empty", 64'(update_valid_o), 64'd0);
    check_counters("t3");
    sync();

    // Counter saturation
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 254; i++) offer(64'h800 + 64'(i), 64'h40 + 64'(i), 64'h0);
    check64("t4_mis_fe", 64'(mispredict_cnt_o), 64'hFE);
    for (int i = 0; i < 3; i++) begin
      offer(64'h900 + 64'(i), 64'h77 + 64'(i), 64'h0);
      check64($sformatf("t4_mis_sat%0d", i), 64'(mispredict_cnt_o), 64'hFF);
    end
    check64("t4_res_sat", 64'(resolve_cnt_o), 64'hFF);
    check_counters("t4");
    repeat (3) sync();

    // Reset with three entries queued
    upd_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) offer(64'hA00 + 64'(i), 64'hB00 + 64'(i), 64'h0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    model_clear();
    upd_stall_i = 1'b0;
    @(negedge clk);
    check64("t5_valid", 64'(update_valid_o), 64'd0);
    check64("t5_ready", 64'(res_ready_o), 64'd1);
    check64("t5_pc", update_pc_o, 64'd0);
    check_counters("t5");
    repeat (5) sync();

    // Correct prediction: filtered build emits no update
    offer(64'h100, 64'h300, 64'h300);
    @(negedge clk);
    check64("t6_last", last_target_o, 64'h300);
    check64("t6_res", 64'(resolve_cnt_o), 64'd1);
    check64("t6_mis", 64'(mispredict_cnt_o), 64'd0);
`ifdef IBP_UPD_FILTER_EN
    check64("t6_valid", 64'(update_valid_o), 64'd0);
`else
    check64("t6_valid", 64'(update_valid_o), 64'd1);
    check64("t6_pc", update_pc_o, 64'h100);
`endif
    repeat (4) sync();

    check64("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibp_update_queue.md
Name: ibp_update_queue

Overview:
- Resolution-side companion to the indirect branch predictor: accepts resolved indirect branches from execute/commit, buffers them in a small FIFO, and drives the predictor's update port (valid/pc/target) one entry per cycle.
- Maintains the global last-indirect-target register used as the predictor's lookup history.
- Counts mispredictions for perf monitoring.
- Sits between the branch resolution unit and the predictor's update inputs.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating mispredict and resolve counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- res_valid_i  in  1  resolved indirect branch offered
- res_ready_o  out  1  queue can accept (not full)
- res_pc_i  in  64  PC of resolved branch
- res_target_i  in  64  actual target
- res_pred_target_i  in  64  target predicted at fetch (0 = no prediction)
- upd_stall_i  in  1  predictor update port unavailable this cycle
- update_valid_o  out  1  update strobe to predictor
- update_pc_o  out  64  PC of head entry
- update_target_o  out  64  target of head entry
- last_target_o  out  64  most recent accepted actual target (lookup history)
- mispredict_cnt_o  out  CNT_W  saturating mispredict count
- resolve_cnt_o  out  CNT_W  saturating accepted-resolution count

Behaviour:
- Reset is synchronous and active-low, on the single clock clk. While rst_n=0 at a clk edge:
  - FIFO emptied (rd/wr pointers 0, count 0).
  - last_target_o=0; mispredict_cnt_o=0; resolve_cnt_o=0.
  - Outputs: update_valid_o=0, update_pc_o=0, update_target_o=0, res_ready_o=1.
- Reset mid-operation discards all queued entries; no update is issued for them.
- Accept: a resolution is accepted when res_valid_i && res_ready_o at a clk edge.
- res_ready_o = (count != DEPTH), derived from registered count only.
- No push when full, even if a pop happens in the same cycle.
- Mispredict: accepted entry with res_pred_target_i != res_target_i.
- On accept:
  - last_target_o <= res_target_i, regardless of the filter.
  - resolve_cnt_o increments, saturating at all-ones.
  - mispredict_cnt_o increments if mispredict, saturating at all-ones.
  - Entry {pc, target} is enqueued if the enqueue condition holds (see Optional Feature).
- Drain:
  - update_valid_o = (count != 0) && !upd_stall_i, combinational.
  - update_pc_o/update_target_o show the head entry when count != 0, else 0.
  - When update_valid_o=1 at an edge, the head pops.
- Latency: enqueue at edge N into an empty queue → update_valid_o=1 in the cycle after edge N, if not stalled. No same-cycle bypass.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- upd_stall_i held: head is held stable and nothing pops; accepts continue until full.
- Entries drain in acceptance order. Duplicate PCs are not merged.

Optional Feature:
- Macro: IBP_UPD_FILTER_EN.
- Defined: only mispredicted resolutions are enqueued. Correct predictions still update last_target_o and resolve_cnt_o but generate no predictor update.
- Undefined: every accepted resolution is enqueued.

Decomposition:
- Shared package bp_pkg:
  - typedef ibp_upd_t {pc[63:0], target[63:0]}.
  - Constant IBP_UPD_DEPTH=4.
  - Saturating-increment function.
- Sub-module bp_sync_fifo: generic synchronous FIFO parameterised on DEPTH and payload type, with push/pop/full/empty/count ports. ibp_update_queue instantiates it.

Test Plan:
- Reset then single resolve (pc=0x1000, target=0x2000, pred=0x0): update_valid_o=1 the cycle after accept with pc=0x1000, target=0x2000; last_target_o=0x2000; mispredict_cnt_o=1; resolve_cnt_o=1.
- Hold upd_stall_i=1, offer 5 back-to-back resolves (pc=0x10..0x50): first 4 accepted, res_ready_o=0 on the 5th. Release stall: 4 updates in order 0x10..0x40 on consecutive cycles; res_ready_o returns to 1 after the first pop.
- Continuous push+pop at full rate for 10 entries with no stall: count stays at 1, updates in order with 1-cycle latency, pointer wrap verified past DEPTH.
- Force mispredict_cnt to 0xFFFE, then 3 mispredicted resolves: counter reads 0xFFFF and stays.
- Queue holding 3 entries, assert rst_n=0 for one edge: update_valid_o=0, res_ready_o=1, all counters and last_target_o = 0; no further updates emitted.
- With IBP_UPD_FILTER_EN: resolve pc=0x100, pred=target=0x300 → no update, last_target_o=0x300, resolve_cnt_o=1, mispredict_cnt_o=0. Without the macro, the same stimulus yields one update.
